lfsr_seq_ctrl: RTL and testbench
================================

Name: lfsr_seq_ctrl

Overview:
- Sequencer for the 8-bit serial-output LFSR datapath.
- Accepts a seed request from a host, then performs these steps in order:
  - loads the seed into the LFSR;
  - runs the LFSR for a fixed number of enable cycles;
  - drains the serial output (LSB first) into a parallel result word;
  - reports done/err.
- Sits between a host/register block and the LFSR instance. It replaces the bench-style hand sequencing of enable/out_enable.

Parameters:
- WIDTH, 8, LFSR width and result word width.
- RUN_CYCLES, 10, number of cycles lfsr_enable is held high per request (>=1).
- TIMEOUT, 16, max consecutive cycles in DRAIN without lfsr_valid before abort with error (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- seed  in  WIDTH  seed for the request; captured when start is accepted.
- abort  in  1  synchronous cancel; returns to IDLE from any state.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of request (success or timeout).
- err  out  1  valid with done; 1 = DRAIN timeout. Held until next accepted start.
- result  out  WIDTH  captured word, bit k = k-th serial bit. Held until next accepted start.
- lfsr_seed  out  WIDTH  seed to LFSR; driven from the latched seed.
- lfsr_load  out  1  one-cycle pulse; LFSR loads lfsr_seed.
- lfsr_enable  out  1  LFSR run/shift enable.
- lfsr_out_enable  out  1  LFSR serial output enable.
- lfsr_out  in  1  LFSR serial bit.
- lfsr_valid  in  1  lfsr_out is valid this cycle.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE;
  - busy, done, err, lfsr_load, lfsr_enable, lfsr_out_enable = 0;
  - result, lfsr_seed, counters = 0.
- All outputs are registered. Reset mid-request abandons it immediately; no done is issued.
- IDLE:
  - start=1 latches seed into lfsr_seed, clears result and err, then goes to LOAD.
  - start is ignored in every other state (no queuing).
- LOAD (1 cycle):
  - lfsr_load=1;
  - next state RUN, run_cnt=0.
- RUN:
  - lfsr_enable=1 for exactly RUN_CYCLES cycles; run_cnt counts 0..RUN_CYCLES-1;
  - on the last cycle, go to DRAIN with bit_cnt=0, to_cnt=0.
- DRAIN:
  - lfsr_out_enable=1, lfsr_enable=0.
  - On each rising edge with lfsr_valid=1:
    - result[bit_cnt] <= lfsr_out, bit_cnt++, to_cnt=0;
    - when bit_cnt==WIDTH-1 is captured, go to DONE with err=0.
  - Cycles with lfsr_valid=0 stall capture and increment to_cnt.
  - When to_cnt reaches TIMEOUT-1 with valid still 0, go to DONE with err=1. The partial result is kept and uncaptured bits stay 0.
  - Valid may drop and reassert mid-word; bits are captured only on valid cycles.
- DONE (1 cycle):
  - done=1, all lfsr_* controls 0;
  - next state IDLE. start in the DONE cycle is ignored.
- abort=1 in any state:
  - next state IDLE; all lfsr_* controls deassert on the next edge;
  - no done pulse, err unchanged, result keeps its partial value.
  - abort has priority over start and over all other transitions.
- Latency with lfsr_valid held 1 in DRAIN: done asserts 2+RUN_CYCLES+WIDTH cycles after the start edge (20 at defaults).
- Widths:
  - bit_cnt spans $clog2(WIDTH) bits;
  - run_cnt and to_cnt are sized by $clog2 of their parameter, minimum 1 bit.
  - No counter wraps: each is cleared on state entry.

Test Plan:
- Nominal:
  - Stimulus: seed=8'h93, start pulse; stub LFSR asserts valid continuously in DRAIN and serves 8'hA5 LSB first.
  - Response: lfsr_load pulse 1 cycle after start; lfsr_enable high exactly 10 cycles; done 20 cycles after start; result=8'hA5, err=0.
- Stalled valid:
  - Stimulus: same as nominal, but valid toggles 1,0,0,1... with gaps of 2 cycles.
  - Response: result=8'hA5, err=0; done is delayed by exactly the number of 0-valid cycles.
- Timeout:
  - Stimulus: stub delivers 3 bits (1,0,1), then valid stays 0.
  - Response: done with err=1 after 16 idle cycles; result=8'h05; busy drops the cycle after done.
- Abort in RUN:
  - Stimulus: abort at run cycle 4.
  - Response: lfsr_enable=0 on the next edge, state IDLE, no done. A following start with seed=8'h3C completes normally with lfsr_seed=8'h3C.
- Start while busy:
  - Stimulus: second start with seed=8'hFF during DRAIN.
  - Response: ignored; lfsr_seed stays 8'h93 and exactly one done is seen.
- Async reset:
  - Stimulus: assert rst mid-DRAIN, off the clock edge.
  - Response: all outputs 0 immediately, without waiting for clk; after release, IDLE with busy=0.

Source files
------------

// File: rtl/lfsr_seq_ctrl.sv
// Sequencer for an 8-bit serial-output LFSR: seed load, fixed run,
// serial drain into a parallel word, done/err report.
module lfsr_seq_ctrl #(
    parameter int WIDTH      = 8,
    parameter int RUN_CYCLES = 10,
    parameter int TIMEOUT    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] seed,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] lfsr_seed,
    output logic             lfsr_load,
    output logic             lfsr_enable,
    output logic             lfsr_out_enable,
    input  logic             lfsr_out,
    input  logic             lfsr_valid
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int RW = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [RW-1:0] RUN_LAST = RW'(RUN_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t          state;
    logic [BW-1:0]   bit_cnt;
    logic [RW-1:0]   run_cnt;
    logic [TW-1:0]   to_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            busy            <= 1'b0;
            done            <= 1'b0;
            err             <= 1'b0;
            result          <= '0;
            lfsr_seed       <= '0;
            lfsr_load       <= 1'b0;
            lfsr_enable     <= 1'b0;
            lfsr_out_enable <= 1'b0;
            bit_cnt         <= '0;
            run_cnt         <= '0;
            to_cnt          <= '0;
        end else begin
            done      <= 1'b0;
            lfsr_load <= 1'b0;
            // abort wins over every other transition, including start
            if (abort) begin
                state           <= IDLE;
                busy            <= 1'b0;
                lfsr_enable     <= 1'b0;
                lfsr_out_enable <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            lfsr_seed <= seed;
                            result    <= '0;
                            err       <= 1'b0;
                            busy      <= 1'b1;
                            lfsr_load <= 1'b1;
                            state     <= LOAD;
                        end
                    end
                    LOAD: begin
                        run_cnt     <= '0;
                        lfsr_enable <= 1'b1;
                        state       <= RUN;
                    end
                    RUN: begin
                        if (run_cnt == RUN_LAST) begin
                            lfsr_enable     <= 1'b0;
                            lfsr_out_enable <= 1'b1;
                            bit_cnt         <= '0;
                            to_cnt          <= '0;
                            state           <= DRAIN;
                        end else begin
                            run_cnt <= run_cnt + 1'b1;
                        end
                    end
                    DRAIN: begin
                        if (lfsr_valid) begin
                            result[bit_cnt] <= lfsr_out;
                            to_cnt          <= '0;
                            if (bit_cnt == BIT_LAST) begin
                                err             <= 1'b0;
                                done            <= 1'b1;
                                lfsr_out_enable <= 1'b0;
                                state           <= DONE;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else if (to_cnt == TO_LAST) begin
                            err             <= 1'b1;
                            done            <= 1'b1;
                            lfsr_out_enable <= 1'b0;
                            state           <= DONE;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end
                    DONE: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Scoreboard bench for lfsr_seq_ctrl with a registered stub LFSR
// whose per-cycle valid pattern is chosen by the stimulus.
module tb_lfsr_seq_ctrl;

    localparam int WIDTH   = 8;
    localparam int RUN     = 10;
    localparam int TIMEOUT = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] seed = '0;
    logic             abort = 1'b0;
    logic             busy, done, err;
    logic [WIDTH-1:0] result, lfsr_seed;
    logic             lfsr_load, lfsr_enable, lfsr_out_enable;
    logic             lfsr_out, lfsr_valid;

    lfsr_seq_ctrl #(
        .WIDTH(WIDTH),
        .RUN_CYCLES(RUN),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .seed(seed),
        .abort(abort),
        .busy(busy),
        .done(done),
        .err(err),
        .result(result),
        .lfsr_seed(lfsr_seed),
        .lfsr_load(lfsr_load),
        .lfsr_enable(lfsr_enable),
        .lfsr_out_enable(lfsr_out_enable),
        .lfsr_out(lfsr_out),
        .lfsr_valid(lfsr_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             err;
        logic [WIDTH-1:0] seed;
        int               lat;
        int               start_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   en_cnt = 0;
    bit   chk_idle = 0;

    logic [WIDTH-1:0] stub_data = '0;
    logic [255:0]     stub_vpat = '0;
    int               sj = 0;
    int               sidx = 0;

    always @(posedge clk) cyc++;

    // Stub LFSR: valid/out are registered off lfsr_out_enable
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_valid <= 1'b0;
            lfsr_out   <= 1'b0;
            sj = 0;
            sidx = 0;
        end else if (lfsr_load) begin
            lfsr_valid <= 1'b0;
            sj = 0;
            sidx = 0;
        end else if (lfsr_out_enable) begin
            lfsr_valid <= (sj < 256) ? stub_vpat[sj] : 1'b0;
            lfsr_out   <= (sidx < WIDTH) ? stub_data[sidx] : 1'b0;
            if (sj < 256 && stub_vpat[sj]) sidx++;
            sj++;
        end else begin
            lfsr_valid <= 1'b0;
        end
    end

    task automatic check(input bit ok, input string name,
                         input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reference: DRAIN cycle c sees valid vp[c-1] (stub adds one cycle);
    // a run of TIMEOUT valid-less cycles ends the request with err.
    function automatic void model(input logic [WIDTH-1:0] d,
                                  input logic [255:0] vp,
                                  output logic [WIDTH-1:0] r,
                                  output logic e, output int lat);
        int got = 0;
        int zrun = 0;
        r = '0;
        e = 1'b0;
        lat = -1;
        for (int c = 0; c < 250; c++) begin
            if (c > 0 && vp[c-1]) begin
                r[got] = d[got];
                got++;
                zrun = 0;
                if (got == WIDTH) begin
                    lat = RUN + 2 + c;
                    return;
                end
            end else begin
                zrun++;
                if (zrun == TIMEOUT) begin
                    e = 1'b1;
                    lat = RUN + 2 + c;
                    return;
                end
            end
        end
    endfunction

    // Monitor: pops the scoreboard whenever done is presented
    always @(negedge clk) begin
        if (chk_idle) begin
            check(!busy && !done, "busy_after_done", {busy, done}, 0);
            chk_idle = 0;
        end
        if (lfsr_load) en_cnt = 0;
        else if (lfsr_enable) en_cnt++;
        if (!rst && done) begin
            if (sb.size() == 0) begin
                check(0, "unexpected_done", 1, 0);
            end else begin
                exp_t x;
                x = sb.pop_front();
                check(result == x.res, "result", result, x.res);
                check(err == x.err, "err", err, x.err);
                check(cyc - x.start_cyc == x.lat, "latency",
                      cyc - x.start_cyc, x.lat);
                check(lfsr_seed == x.seed, "lfsr_seed", lfsr_seed, x.seed);
                check(en_cnt == RUN, "enable_cycles", en_cnt, RUN);
                check(busy, "busy_with_done", busy, 1);
                last_exp = x;
            end
            chk_idle = 1;
        end
    end

    task automatic issue(input logic [WIDTH-1:0] s,
                         input logic [WIDTH-1:0] d,
                         input logic [255:0] vp);
        exp_t x;
        @(negedge clk);
        stub_data = d;
        stub_vpat = vp;
        model(d, vp, x.res, x.err, x.lat);
        x.seed = s;
        x.start_cyc = cyc + 1;
        sb.push_back(x);
        seed = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check(lfsr_load && busy, "load_pulse", {lfsr_load, busy}, 3);
        check(lfsr_seed == s, "seed_latch", lfsr_seed, s);
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check(0, "done_timeout", n, 0);
            sb.delete();
        end else begin
            repeat (2) @(negedge clk);
            check(result == last_exp.res && err == last_exp.err,
                  "held_result", {err, result}, {last_exp.err, last_exp.res});
        end
    endtask

    function automatic logic [255:0] pat_repeat(input int gap);
        logic [255:0] p = '0;
        for (int i = 0; i < 256; i++) p[i] = (i % (gap + 1)) == 0;
        return p;
    endfunction

    initial begin
        logic [255:0] vp;
        repeat (3) @(negedge clk);
        check({busy, done, err, lfsr_load, lfsr_enable, lfsr_out_enable} == 0
              && result == 0 && lfsr_seed == 0, "reset_state",
              {busy, done, err, result, lfsr_seed}, 0);
        rst = 1'b0;
        @(negedge clk);

        // nominal
        issue(8'h93, 8'hA5, '1);
        wait_done();

        // stalled valid: 1,0,0,1,... adds 14 cycles
        issue(8'h93, 8'hA5, pat_repeat(2));
        wait_done();

        // timeout after three bits 1,0,1
        vp = '0;
        vp[2:0] = 3'b111;
        issue(8'h93, 8'hFD, vp);
        wait_done();
        check(result == 8'h05 && err, "timeout_result", {err, result}, 9'h105);

        // abort during RUN
        issue(8'h11, 8'h5A, '1);
        void'(sb.pop_back());
        while (!lfsr_enable) @(negedge clk);
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check(!lfsr_enable && !busy && !done, "abort_idle",
              {lfsr_enable, busy, done}, 0);
        repeat (30) @(negedge clk);
        issue(8'h3C, 8'h69, '1);
        wait_done();

        // start while busy is ignored
        issue(8'h93, 8'hC3, '1);
        repeat (14) @(negedge clk);
        seed = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check(lfsr_seed == 8'h93, "busy_start_ignored", lfsr_seed, 8'h93);
        wait_done();
        repeat (25) @(negedge clk);

        // async reset mid-DRAIN
        issue(8'h77, 8'h81, '1);
        repeat (14) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check({busy, done, err, lfsr_load, lfsr_enable, lfsr_out_enable} == 0
              && result == 0 && lfsr_seed == 0, "async_reset",
              {busy, lfsr_out_enable, result, lfsr_seed}, 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check(!busy && !done, "post_reset_idle", {busy, done}, 0);

        // randomized requests
        for (int t = 0; t < 24; t++) begin
            int prob = $urandom_range(0, 2) == 0 ? 100 :
                       ($urandom_range(0, 1) ? 60 : 30);
            for (int i = 0; i < 256; i++)
                vp[i] = $urandom_range(0, 99) < prob;
            if ($urandom_range(0, 3) == 0) begin
                int k = $urandom_range(0, 12);
                for (int i = k; i < k + 20; i++) vp[i] = 1'b0;
            end
            issue(WIDTH'($urandom), WIDTH'($urandom), vp);
            wait_done();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
